// File: rtl/a_rd_cross_ram_buf.sv
// a_rd_cross_ram_buf: N-way RAM read-return selector feeding a registered output FIFO.
// Beats from the selected channel are queued; beats arriving while full are counted as drops.
module a_rd_cross_ram_buf #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int DEPTH    = 2,
    parameter int SEL_MODE = 0,
    localparam int CW      = (N > 2) ? N - 1 : 1,
    localparam int SW      = (N > 2) ? $clog2(N) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [CW-1:0]   ctrl_i,
    input  logic [N*DW-1:0] data_i,
    input  logic [N-1:0]    dv_i,
    input  logic            clr_i,
    output logic [DW-1:0]   data_o,
    output logic            dv_o,
    input  logic            ready_i,
    output logic            overflow_o,
    output logic [7:0]      drop_cnt_o,
    output logic [SW-1:0]   sel_o
);
    logic [DW-1:0] chan [N];
    logic [DW-1:0] mem_q [DEPTH];
    logic [SW-1:0] psel, bsel, sel, sel_q, sel_d;
    logic          sel_ok, push, pop, full, wr_en, drop;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nx;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d, wdata;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign chan[g] = data_i[g*DW +: DW];
    end

    // Priority: ascending scan so the highest set bit is the last (winning) assignment.
    always_comb begin
        psel = '0;
        for (int k = 1; k < N; k++)
            if (ctrl_i[k-1]) psel = SW'(k);
    end

    assign bsel   = ctrl_i[SW-1:0];
    assign sel    = (SEL_MODE == 0) ? psel : bsel;
    assign sel_ok = (SEL_MODE == 0) || (32'(bsel) < 32'(N));
    assign wdata  = chan[sel];

    assign dv_o  = cnt_q != '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign pop   = dv_o && ready_i;
    assign push  = sel_ok && dv_i[sel];
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign rd_nx = rd_q + AW'(1);

    // The head is registered so data_o holds its last value once the FIFO drains.
    always_comb begin
        sel_d  = sel_ok ? sel : sel_q;
        rd_d   = pop ? rd_nx : rd_q;
        wr_d   = wr_en ? wr_q + AW'(1) : wr_q;
        cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        head_d = pop ? ((cnt_q > (AW+1)'(1)) ? mem_q[rd_nx] : (wr_en ? wdata : head_q))
                     : ((!dv_o && wr_en) ? wdata : head_q);
        ovf_d  = clr_i ? 1'b0 : (ovf_q | drop);
        drop_d = clr_i ? 8'd0 : ((drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            sel_q  <= sel_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= wdata;
    end

    assign data_o     = head_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;
    assign sel_o      = sel_q;
endmodule

// File: doc/a_rd_cross_ram_buf.md
Name: a_rd_cross_ram_buf

Overview:
- Parametrised, registered successor to the 4-way RAM read-return crossbar.
- Selects one of N RAM read channels, using either legacy priority selection or binary-index selection.
- Captures data beats from the selected channel into an output FIFO with a valid/ready handshake.
- Counts beats dropped on overflow. Sits between the banked RAM read ports and the emulation control readback path.

Parameters:
- N, 4, number of read channels (2..16).
- DW, 16, data width per channel.
- DEPTH, 2, output FIFO depth (power of 2, 2..16).
- SEL_MODE, 0, 0 = priority select (highest set ctrl bit wins, all-zero selects channel 0); 1 = binary index in ctrl_i[clog2(N)-1:0].

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ctrl_i  in  N-1 (min 1)  channel select. Priority mode: bit k-1 selects channel k. Binary mode: low clog2(N) bits used, the rest are ignored.
- data_i  in  N*DW  concatenated channel data; channel k occupies [k*DW +: DW].
- dv_i  in  N  per-channel data-valid, single-cycle pulses.
- clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
- data_o  out  DW  FIFO head data.
- dv_o  out  1  FIFO non-empty; head valid.
- ready_i  in  1  consumer accepts head when dv_o && ready_i.
- overflow_o  out  1  sticky: a selected beat was dropped.
- drop_cnt_o  out  8  saturating count of dropped beats.
- sel_o  out  clog2(N) (min 1)  currently decoded channel index, registered.

Behaviour:
- Reset (async assert, sync release): FIFO emptied, dv_o=0, data_o=0, overflow_o=0, drop_cnt_o=0, sel_o=0.
- Select decode is combinational from ctrl_i in the same cycle.
- Priority mode: scan from the highest bit down; the first set bit at position k-1 gives channel k.
- Binary mode: an index >= N selects nothing; no beat is captured and no drop is counted.
- sel_o is the registered decoded index and lags ctrl_i by 1 cycle. In binary mode with an invalid index, sel_o holds its previous value.
- Capture: when dv_i[sel] is 1 in cycle t, data_i[sel] is written at edge t.
  - The write is visible at dv_o/data_o from cycle t+1, giving 1-cycle latency when the FIFO is empty.
- dv on non-selected channels is ignored entirely; those beats are neither captured nor counted.
- Pop occurs on dv_o && ready_i. data_o always shows the FIFO head; with the FIFO empty, data_o holds its last value (0 after reset).
- Simultaneous push and pop:
  - Always permitted, including when the FIFO is full, because the pop frees a slot in the same edge.
  - The occupancy count is unchanged.
  - When depth is 1, the head advances to the new beat.
- Full, no pop, selected dv=1: the beat is dropped and the FIFO contents are unchanged.
  - overflow_o sets at that edge.
  - drop_cnt_o increments and saturates at 255.
- clr_i=1: overflow_o and drop_cnt_o go to 0 at the next edge.
  - If a drop occurs in the same cycle, clr wins. That drop is lost from the count.
- Pointers: rd/wr pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy uses clog2(DEPTH)+1 bits. Full means occupancy==DEPTH; empty means occupancy==0.
- A mid-operation ctrl_i change takes effect in the same cycle for capture. Data already in the FIFO is unaffected.
- A reset asserted mid-stream discards FIFO contents immediately (async); outputs take their reset values without waiting for a clock.
- ready_i with an empty FIFO is a no-op.

Test Plan:
- Priority mode, N=4: ctrl_i=3'b110, dv_i=4'b1000, data_i[3]=16'hA5A5 -> dv_o=1 and data_o=16'hA5A5 the next cycle; sel_o=3. Then ctrl_i=3'b000 with dv_i[0] pulse, data 16'h0001 -> channel 0 captured.
- Non-selected ignore: ctrl_i=3'b001 (channel 1), pulse dv_i[2] with 16'h2222 -> dv_o stays 0 and drop_cnt_o stays 0.
- Backpressure, DEPTH=2, ready_i=0: push 16'h0010, 16'h0011, 16'h0012 on consecutive cycles -> FIFO holds 0010, 0011; overflow_o=1; drop_cnt_o=1. Then ready_i=1 pops 0010 then 0011, and dv_o drops after the 2nd pop.
- Full with simultaneous push and pop: FIFO full, ready_i=1, and dv with 16'h00FF in the same cycle -> occupancy stays 2; the head sequence continues in order with 00FF last; no drop counted.
- Binary mode, N=4: ctrl_i[1:0]=2 captures channel 2. Then 300 dropped beats -> drop_cnt_o saturates at 255. clr_i=1 -> drop_cnt_o=0 and overflow_o=0 next cycle.
- Async reset with 2 entries queued: assert rst_n_i=0 between clock edges -> dv_o=0 and data_o=0 immediately; after release, the first new capture appears at 1-cycle latency.
